// File: rtl/axil_pkg.sv
// Shared AXI4-lite definitions: response codes, AxPROT bit positions,
// read/write responder FSM state encodings and the address-window decode helper.
// Used by the memory responder and by the riscv core's initiator side.
package axil_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    // Bit positions inside awprot/arprot.
    localparam int PROT_PRIV   = 0;
    localparam int PROT_NONSEC = 1;
    localparam int PROT_INSTR  = 2;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_COMMIT,
        W_RESP
    } wr_state_t;

    // True when base <= addr < base + span. Done in 33 bits so a window
    // that ends exactly at 2^32 still decodes correctly.
    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [32:0] span);
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return (addr >= base) && (off < span);
    endfunction

endpackage

// File: rtl/axil_mem_responder_if.sv
// AXI4-lite bus bundle between the CPU initiator and the memory responder.
// Ports: aw*/w*/b* write channels, ar*/r* read channels; master drives
// valids/addresses/data/readies of the response channels, slave drives the rest.
interface axil_mem_responder_if
    import axil_pkg::*;
();
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddress;
    logic [2:0]  awprot;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wrstrb;
    logic        bvalid;
    logic        bready;
    resp_t       bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddress;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    resp_t       rresp;

    modport master (
        output awvalid, awaddress, awprot, wvalid, wdata, wrstrb, bready,
               arvalid, araddress, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddress, awprot, wvalid, wdata, wrstrb, bready,
               arvalid, araddress, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axil_mem_array.sv
// DEPTH x 32 RAM: one synchronous read port, one byte-enabled synchronous write port.
// Latency: rd_data valid the cycle after rd_en; writes land on the enabling edge.
// Backpressure: none; a same-edge read and write of one word returns the old value.
module axil_mem_array
    import axil_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [3:0]    wr_be,
    input  logic [31:0]   wr_data
);

    logic [31:0] mem [DEPTH];

    // Storage is deliberately not reset; rd_data holds until the next rd_en.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axil_mem_responder.sv
// AXI4-lite responder RAM with independent read and write FSMs and window decode.
// Latency: rvalid 1 cycle after AR accept; bvalid 2 cycles after the later of AW/W.
// Backpressure: rdata/bresp held until rready/bready; readys low while a response is pending.
// Ports: clk, reset (async, active-high), bus (axil_mem_responder_if.slave).
// Optional AXIL_MEM_PROT_CHECK_EN: instruction writes and unprivileged reads get SLVERR.
module axil_mem_responder
    import axil_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    axil_mem_responder_if.slave bus
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    // ---------------- read channel ----------------
    rd_state_t     rd_state;
    logic          arready_q;
    logic          rvalid_q;
    logic          rd_zero;     // rdata forced to 0 (after reset or on an error response)
    resp_t         rresp_q;
    resp_t         ar_resp;
    logic          ar_hs;
    logic          rd_en;
    logic [AW-1:0] rd_idx;
    logic [31:0]   mem_rdata;

    assign ar_hs  = bus.arvalid && arready_q;
    assign rd_idx = AW'((bus.araddress - BASE_ADDR) >> 2);

    // DECERR wins over SLVERR.
    always_comb begin
        ar_resp = RESP_OKAY;
        if (!addr_in_window(bus.araddress, BASE_ADDR, SPAN)) begin
            ar_resp = RESP_DECERR;
        end
`ifdef AXIL_MEM_PROT_CHECK_EN
        else if (!bus.arprot[PROT_PRIV]) begin
            ar_resp = RESP_SLVERR;
        end
`endif
    end

    // The RAM read is launched on the accepting edge so the word is in
    // mem_rdata by the first R_RESP cycle.
    assign rd_en = ar_hs && (ar_resp == RESP_OKAY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rd_zero   <= 1'b1;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rresp_q   <= ar_resp;
                        rd_zero   <= (ar_resp != RESP_OKAY);
                        rd_state  <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (bus.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rd_state  <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rd_zero ? 32'h0 : mem_rdata;

    // ---------------- write channel ----------------
    wr_state_t     wr_state;
    logic          awready_q;
    logic          wready_q;
    logic          aw_held;
    logic          w_held;
    logic          bvalid_q;
    resp_t         bresp_q;
    resp_t         wr_resp;
    logic [31:0]   aw_addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          aw_hs;
    logic          w_hs;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
`ifdef AXIL_MEM_PROT_CHECK_EN
    logic          aw_instr_q;
`else
    logic          unused_prot;
    assign unused_prot = ^{bus.awprot, bus.arprot};
`endif

    assign aw_hs  = bus.awvalid && awready_q;
    assign w_hs   = bus.wvalid && wready_q;
    assign wr_idx = AW'((aw_addr_q - BASE_ADDR) >> 2);

    always_comb begin
        wr_resp = RESP_OKAY;
        if (!addr_in_window(aw_addr_q, BASE_ADDR, SPAN)) begin
            wr_resp = RESP_DECERR;
        end
`ifdef AXIL_MEM_PROT_CHECK_EN
        else if (aw_instr_q) begin
            wr_resp = RESP_SLVERR;
        end
`endif
    end

    // Only an OKAY write touches storage; wrstrb=0 is an OKAY no-op.
    assign wr_en = (wr_state == W_COMMIT) && (wr_resp == RESP_OKAY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state   <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            aw_addr_q  <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
`ifdef AXIL_MEM_PROT_CHECK_EN
            aw_instr_q <= 1'b0;
`endif
        end else begin
            case (wr_state)
                W_IDLE: begin
                    // Each half is latched on its own and held for its partner.
                    if (aw_hs) begin
                        aw_held   <= 1'b1;
                        awready_q <= 1'b0;
                        aw_addr_q <= bus.awaddress;
`ifdef AXIL_MEM_PROT_CHECK_EN
                        aw_instr_q <= bus.awprot[PROT_INSTR];
`endif
                    end else begin
                        awready_q <= !aw_held;
                    end
                    if (w_hs) begin
                        w_held   <= 1'b1;
                        wready_q <= 1'b0;
                        wdata_q  <= bus.wdata;
                        wstrb_q  <= bus.wrstrb;
                    end else begin
                        wready_q <= !w_held;
                    end
                    if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                        wr_state <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    bvalid_q <= 1'b1;
                    bresp_q  <= wr_resp;
                    wr_state <= W_RESP;
                end
                W_RESP: begin
                    if (bus.bready) begin
                        bvalid_q  <= 1'b0;
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wr_state  <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;

    axil_mem_array #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (mem_rdata),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_be   (wstrb_q),
        .wr_data (wdata_q)
    );

endmodule
